// File: rtl/calc_sequencer.sv
// Key-entry sequencer for a BCD calculator: collects two operands and an operator,
// hands them to an external ALU, and drives the display with entry, result or error.
module calc_sequencer #(
  parameter int DIGITS  = 6,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_valid,
  input  logic [3:0]          key_code,
  output logic                alu_start,
  output logic [1:0]          alu_op,
  output logic [4*DIGITS-1:0] alu_a,
  output logic [4*DIGITS-1:0] alu_b,
  input  logic                alu_done,
  input  logic [4*DIGITS-1:0] alu_result,
  input  logic                alu_err,
  output logic [4*DIGITS-1:0] disp_data,
  output logic                disp_err,
  output logic                busy
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] ERR_PAT = {DIGITS{4'hE}};

  typedef enum logic [2:0] {ENTER_A, ENTER_B, RUN, WAIT, SHOW, ERROR} state_t;

  state_t         state_q, state_n;
  logic [W-1:0]   a_q, a_n, b_q, b_n;
  logic [CW-1:0]  count_q, count_n;
  logic [1:0]     op_q, op_n, pend_q, pend_n;
  logic           chain_q, chain_n;
  logic [TW-1:0]  timer_q, timer_n;
  logic           alu_start_n, disp_err_n, busy_n;
  logic [1:0]     alu_op_n;
  logic [W-1:0]   alu_a_n, alu_b_n, disp_n;

  logic is_digit, is_op, is_eq, is_clr, room;

  function automatic logic [W-1:0] push_digit(input logic [W-1:0] v, input logic [3:0] d);
    return {v[W-5:0], d};
  endfunction

  // A..D map onto 0..3 by subtracting the code of A modulo 4.
  function automatic logic [1:0] decode_op(input logic [3:0] k);
    return 2'(k - 4'hA);
  endfunction

  assign is_digit = key_valid && (key_code <= 4'd9);
  assign is_op    = key_valid && (key_code >= 4'hA) && (key_code <= 4'hD);
  assign is_eq    = key_valid && (key_code == 4'hE);
  assign is_clr   = key_valid && (key_code == 4'hF);
  assign room     = (count_q < CW'(DIGITS));

  always_comb begin
    state_n     = state_q;
    a_n         = a_q;
    b_n         = b_q;
    count_n     = count_q;
    op_n        = op_q;
    pend_n      = pend_q;
    chain_n     = chain_q;
    timer_n     = timer_q;
    alu_start_n = 1'b0;
    alu_op_n    = alu_op;
    alu_a_n     = alu_a;
    alu_b_n     = alu_b;
    disp_n      = disp_data;
    disp_err_n  = disp_err;

    if (is_clr) begin
      state_n    = ENTER_A;
      a_n        = '0;
      b_n        = '0;
      count_n    = '0;
      op_n       = '0;
      pend_n     = '0;
      chain_n    = 1'b0;
      timer_n    = '0;
      alu_op_n   = '0;
      alu_a_n    = '0;
      alu_b_n    = '0;
      disp_n     = '0;
      disp_err_n = 1'b0;
    end else begin
      case (state_q)
        ENTER_A: begin
          if (is_digit && room) begin
            a_n     = push_digit(a_q, key_code);
            count_n = count_q + CW'(1);
            disp_n  = push_digit(a_q, key_code);
          end else if (is_op) begin
            op_n    = decode_op(key_code);
            b_n     = '0;
            count_n = '0;
            state_n = ENTER_B;
          end
        end
        ENTER_B: begin
          if (is_digit && room) begin
            b_n     = push_digit(b_q, key_code);
            count_n = count_q + CW'(1);
            disp_n  = push_digit(b_q, key_code);
          end else if (is_op && count_q == '0) begin
            op_n = decode_op(key_code);
          end else if ((is_op || is_eq) && count_q != '0) begin
            // An operator here both launches the pending calculation and queues the next one.
            pend_n      = is_op ? decode_op(key_code) : pend_q;
            chain_n     = is_op;
            state_n     = RUN;
            alu_start_n = 1'b1;
            alu_a_n     = a_q;
            alu_b_n     = b_q;
            alu_op_n    = op_q;
          end
        end
        RUN: begin
          state_n = WAIT;
          timer_n = '0;
        end
        WAIT: begin
          if (alu_done) begin
            timer_n = '0;
            if (alu_err) begin
              state_n    = ERROR;
              disp_n     = ERR_PAT;
              disp_err_n = 1'b1;
            end else begin
              a_n    = alu_result;
              disp_n = alu_result;
              if (chain_q) begin
                op_n    = pend_q;
                b_n     = '0;
                count_n = '0;
                chain_n = 1'b0;
                state_n = ENTER_B;
              end else begin
                state_n = SHOW;
              end
            end
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            state_n    = ERROR;
            disp_n     = ERR_PAT;
            disp_err_n = 1'b1;
          end else begin
            timer_n = timer_q + TW'(1);
          end
        end
        SHOW: begin
          if (is_digit) begin
            a_n     = W'(key_code);
            count_n = CW'(1);
            disp_n  = W'(key_code);
            state_n = ENTER_A;
          end else if (is_op) begin
            op_n    = decode_op(key_code);
            b_n     = '0;
            count_n = '0;
            state_n = ENTER_B;
          end
        end
        ERROR: ;
        default: state_n = ENTER_A;
      endcase
    end

    busy_n = (state_n == RUN) || (state_n == WAIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ENTER_A;
      a_q       <= '0;
      b_q       <= '0;
      count_q   <= '0;
      op_q      <= '0;
      pend_q    <= '0;
      chain_q   <= 1'b0;
      timer_q   <= '0;
      alu_start <= 1'b0;
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      disp_data <= '0;
      disp_err  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_n;
      a_q       <= a_n;
      b_q       <= b_n;
      count_q   <= count_n;
      op_q      <= op_n;
      pend_q    <= pend_n;
      chain_q   <= chain_n;
      timer_q   <= timer_n;
      alu_start <= alu_start_n;
      alu_op    <= alu_op_n;
      alu_a     <= alu_a_n;
      alu_b     <= alu_b_n;
      disp_data <= disp_n;
      disp_err  <= disp_err_n;
      busy      <= busy_n;
    end
  end

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 SHALL have parameter DIGITS, default 6, meaning the maximum BCD digits per operand (the display width).
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the maximum cycles to wait for alu_done before flagging an error.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port key_valid  input  1  single-cycle key event strobe.
REQ-006 SHALL have port key_code  input  4  key code: 0-9 digit, A add, B sub, C mul, D div, E equals, F clear.
REQ-007 SHALL have port alu_start  output  1  one-cycle compute request.
REQ-008 SHALL have port alu_op  output  2  operator: 0 add, 1 sub, 2 mul, 3 div.
REQ-009 SHALL have ports alu_a, alu_b  output  4*DIGITS  BCD operands.
REQ-010 SHALL have port alu_done  input  1  one-cycle completion strobe.
REQ-011 SHALL have port alu_result  input  4*DIGITS  BCD result, valid with alu_done.
REQ-012 SHALL have port alu_err  input  1  overflow/divide-by-zero flag, valid with alu_done.
REQ-013 SHALL have port disp_data  output  4*DIGITS  BCD digits to the display driver.
REQ-014 SHALL have port disp_err  output  1  error indication.
REQ-015 SHALL have port busy  output  1  compute in flight.

Function
REQ-016 SHALL implement states ENTER_A, ENTER_B, RUN, WAIT, SHOW, ERROR; all outputs registered.
REQ-017 SHALL, in ENTER_A on a digit with fewer than DIGITS digits entered: A <= {A shifted left 4, digit}, count+1; at DIGITS digits, ignore the digit.
REQ-018 SHALL, in ENTER_A on an operator: latch op, clear B and count, go ENTER_B; disp_data keeps showing A until the first B digit arrives.
REQ-019 SHALL, in ENTER_A on equals, ignore the key.
REQ-020 SHALL, in ENTER_B, apply digit entry to B with the same rules as REQ-017; disp_data = B once count > 0.
REQ-021 SHALL, in ENTER_B with count = 0 on an operator, replace op; on equals, ignore the key.
REQ-022 SHALL, in ENTER_B with count > 0 on equals, go RUN with chain = 0.
REQ-023 SHALL, in ENTER_B with count > 0 on an operator, store it as pending op and go RUN with chain = 1.
REQ-024 SHALL, in RUN, assert alu_start for exactly one cycle, with alu_a = A, alu_b = B, alu_op = op; go WAIT next cycle.
REQ-025 SHALL hold alu_a, alu_b and alu_op stable from RUN until WAIT exits.
REQ-026 SHALL, in WAIT on alu_done with alu_err = 1, go ERROR.
REQ-027 SHALL, in WAIT on alu_done with alu_err = 0: A <= alu_result, disp_data <= alu_result; if chain = 1 then op <= pending, B and count cleared, go ENTER_B; else go SHOW.
REQ-028 SHALL, in WAIT, count cycles; with no alu_done after TIMEOUT cycles, go ERROR.
REQ-029 SHALL, in WAIT, ignore every key except clear.
REQ-030 SHALL, in SHOW on a digit: A <= that digit, count = 1, go ENTER_A.
REQ-031 SHALL, in SHOW on an operator: keep the result as A, latch op, go ENTER_B; on equals, ignore the key.
REQ-032 SHALL, in ERROR: disp_err = 1, disp_data all digits 4'hE; ignore every key except clear.
REQ-033 SHALL treat clear in any state as: A, B, count, op, chain and timer zeroed; disp_data = 0; disp_err = 0; go ENTER_A.
REQ-034 SHALL give clear priority when key_valid(clear) and alu_done coincide; the ALU result is discarded.
REQ-035 SHALL update disp_data and state one cycle after the accepted key_valid; alu_start SHALL rise one cycle after the triggering key.
REQ-036 SHALL drive busy = 1 exactly in RUN and WAIT.
REQ-037 SHALL ignore alu_done outside WAIT.

Reset
REQ-038 SHALL, while rst = 1 (asynchronous), force state ENTER_A, all registers 0, and alu_start, busy, disp_err, disp_data, alu_a, alu_b and alu_op = 0; reset mid-WAIT abandons the pending result.

Verification
REQ-039 Keys 1,2,A,3,E, ALU returns 000015 -> alu_start once with alu_a = 000012, alu_b = 000003, alu_op = 0; disp_data = 000015, state SHOW.
REQ-040 Seven digits 1..7 in ENTER_A -> disp_data = 123456; the 7th digit is ignored.
REQ-041 Keys 9,D,0,E, ALU returns alu_err = 1 -> disp_err = 1, disp_data = EEEEEE; further digit keys have no effect; F clears to 000000.
REQ-042 Keys 5,A,5,C (chain), ALU returns 000010 -> ENTER_B with op = mul; keys 2,E -> alu_a = 000010, alu_b = 000002, alu_op = 2.
REQ-043 With no alu_done for TIMEOUT cycles -> ERROR; clear coinciding with alu_done -> ENTER_A, disp_data = 0.
REQ-044 rst asserted during WAIT -> all outputs 0 immediately; a late alu_done is ignored.
